sdpram_line_reader: RTL

Read-side controller for the simple dual-port line-buffer RAM. On a start command it walks a contiguous, wrapping address range on the RAM read port, absorbs the RAM's fixed 1-cycle read latency, and delivers the words as a valid/ready stream with backpressure and an end-of-line marker. It sits between the line buffer and the bicubic interpolation datapath, mirroring the write side that fills the RAM.

---
 rtl/sdpram_line_reader_pkg.sv | 14 +
 rtl/stream_skid_fifo.sv | 67 ++++++
 rtl/sdpram_line_reader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sdpram_line_reader_pkg.sv
// rtl/sdpram_line_reader_pkg.sv - shared types and constants for the line-buffer read controller
package sdpram_line_reader_pkg;

    // Controller phases: waiting for a command, issuing reads, waiting for the tail to drain
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Output FIFO depth; the read credit check is sized against this
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry register FIFO with registered head and same-cycle push/pop
module stream_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;

    // Next state: entry0 is always the head; a pop shifts entry1 forward
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = push_data_i;
                end else begin
                    entry1_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    entry0_d = push_data_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = entry0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/sdpram_line_reader.sv
// rtl/sdpram_line_reader.sv - walks a wrapping RAM address range and streams the words out
module sdpram_line_reader
    import sdpram_line_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  issue;
    logic                  issue_ok;
    logic                  last_one;
    logic [2:0]            credit;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_head;

    assign pop      = m_valid & m_ready;
    assign last_one = (remaining_q == (ADDR_WIDTH+1)'(1));
    // Words already committed to the FIFO after this cycle; an inflight read always lands there
    assign credit   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_ok = (credit < 3'(FIFO_DEPTH));

    // FSM state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (length != '0)) state_d = ISSUE;
            ISSUE:   if (issue_ok && last_one)    state_d = DRAIN;
            DRAIN:   if (pop && m_last)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag and read-issue strobe
    always_comb begin
        busy  = (state_q != IDLE);
        issue = (state_q == ISSUE) && issue_ok;
    end

    // Address/remaining counters, inflight tracking and the done pulse
    always_comb begin
        rd_addr_d       = rd_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        if (state_q == IDLE && start) begin
            if (length != '0) begin
                rd_addr_d   = base_addr;
                remaining_d = length;
            end else begin
                done_d = 1'b1;
            end
        end
        if (issue) begin
            rd_addr_d       = rd_addr_q + 1'b1;
            remaining_d     = remaining_q - 1'b1;
            inflight_d      = 1'b1;
            inflight_last_d = last_one;
        end
        if (state_q == DRAIN && pop && m_last) begin
            done_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr_q       <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            rd_addr_q       <= rd_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // The RAM answers one edge after an issue, so the inflight flag doubles as the push strobe
    stream_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i      (clk),
        .aresetn_i  (aresetn),
        .push_i     (inflight_q),
        .push_data_i({inflight_last_q, rd_data}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .valid_o    (fifo_valid),
        .count_o    (fifo_count)
    );

    assign rd_addr = rd_addr_q;
    assign done    = done_q;
    assign m_valid = fifo_valid;
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    // Stale entries may hold a last tag, so only advertise it alongside valid data
    assign m_last  = fifo_valid & fifo_head[DATA_WIDTH];

endmodule
